// File: rtl/msh_mem_rd_req.sv
// Tagged memory read requester: issues up to four reads with 2-bit tags,
// collects responses in any order and hands data downstream in issue order.
module msh_mem_rd_req #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 64
) (
  input  logic              mclk,
  input  logic              mrst_n,
  input  logic              cmd_vld,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              cmd_rdy,
  output logic              mem_req_vld,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [1:0]        mem_req_tag,
  input  logic              mem_req_rdy,
  input  logic              mem_rsp_vld,
  input  logic [1:0]        mem_rsp_tag,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              rd_vld,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_rdy,
  output logic [2:0]        outstanding,
  output logic              err_unexp_rsp
);

  logic [2:0]        wp_q, wp_d, rp_q, rp_d;
  logic [3:0]        pend_q, pend_d, fill_q, fill_d;
  logic              req_vld_q, req_vld_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [1:0]        req_tag_q, req_tag_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] data_q [4];

  logic [2:0] occ;
  logic       accept, retire, rsp_ok;

  assign occ     = wp_q - rp_q;
  assign cmd_rdy = (occ < 3'd4) && (!req_vld_q || mem_req_rdy);
  assign accept  = cmd_vld && cmd_rdy;
  assign rd_vld  = fill_q[rp_q[1:0]];
  assign rd_data = data_q[rp_q[1:0]];
  assign retire  = rd_vld && rd_rdy;
  // A slot retiring this cycle already has fill set, so its late response is rejected here.
  assign rsp_ok  = mem_rsp_vld && pend_q[mem_rsp_tag] && !fill_q[mem_rsp_tag];

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    pend_d     = pend_q;
    fill_d     = fill_q;
    req_vld_d  = req_vld_q;
    req_addr_d = req_addr_q;
    req_tag_d  = req_tag_q;
    err_d      = mem_rsp_vld && !rsp_ok;
    if (retire) begin
      pend_d[rp_q[1:0]] = 1'b0;
      fill_d[rp_q[1:0]] = 1'b0;
      rp_d              = rp_q + 3'd1;
    end
    if (rsp_ok) begin
      fill_d[mem_rsp_tag] = 1'b1;
    end
    if (accept) begin
      pend_d[wp_q[1:0]] = 1'b1;
      wp_d              = wp_q + 3'd1;
      req_vld_d         = 1'b1;
      req_addr_d        = cmd_addr;
      req_tag_d         = wp_q[1:0];
    end else if (req_vld_q && mem_req_rdy) begin
      req_vld_d = 1'b0;
    end
  end

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      pend_q     <= '0;
      fill_q     <= '0;
      req_vld_q  <= 1'b0;
      req_addr_q <= '0;
      req_tag_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      pend_q     <= pend_d;
      fill_q     <= fill_d;
      req_vld_q  <= req_vld_d;
      req_addr_q <= req_addr_d;
      req_tag_q  <= req_tag_d;
      err_q      <= err_d;
    end
  end

  // Data buffer is qualified by fill, so it needs no reset.
  always_ff @(posedge mclk) begin
    if (rsp_ok) begin
      data_q[mem_rsp_tag] <= mem_rsp_data;
    end
  end

  assign mem_req_vld   = req_vld_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_tag   = req_tag_q;
  assign outstanding   = occ;
  assign err_unexp_rsp = err_q;

endmodule

// File: tb/tb_msh_mem_rd_req.sv
// Scoreboard bench for msh_mem_rd_req: random and directed reads against an
// in-order queue model with a randomly reordering memory responder.
module tb_msh_mem_rd_req;
  localparam int AW = 20;
  localparam int DW = 64;

  logic          mclk = 1'b0;
  logic          mrst_n = 1'b0;
  logic          cmd_vld = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic          cmd_rdy;
  logic          mem_req_vld;
  logic [AW-1:0] mem_req_addr;
  logic [1:0]    mem_req_tag;
  logic          mem_req_rdy = 1'b0;
  logic          mem_rsp_vld = 1'b0;
  logic [1:0]    mem_rsp_tag = '0;
  logic [DW-1:0] mem_rsp_data = '0;
  logic          rd_vld;
  logic [DW-1:0] rd_data;
  logic          rd_rdy = 1'b0;
  logic [2:0]    outstanding;
  logic          err_unexp_rsp;

  msh_mem_rd_req #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .mclk(mclk), .mrst_n(mrst_n),
    .cmd_vld(cmd_vld), .cmd_addr(cmd_addr), .cmd_rdy(cmd_rdy),
    .mem_req_vld(mem_req_vld), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_rdy(mem_req_rdy),
    .mem_rsp_vld(mem_rsp_vld), .mem_rsp_tag(mem_rsp_tag), .mem_rsp_data(mem_rsp_data),
    .rd_vld(rd_vld), .rd_data(rd_data), .rd_rdy(rd_rdy),
    .outstanding(outstanding), .err_unexp_rsp(err_unexp_rsp)
  );

  always #5 mclk = ~mclk;

  typedef struct packed { logic [1:0] tag; logic [AW-1:0] addr; } req_t;
  typedef struct packed { logic [1:0] tag; logic [DW-1:0] data; } rsp_t;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: reads retire in issue order; tag = issue index mod 4
  int            cnt = 0;
  logic [1:0]    next_tag = '0;
  logic [1:0]    tag_q[$];
  logic [DW-1:0] exp_q[$];
  req_t          req_q[$];
  rsp_t          mem_q[$];
  logic [1:0]    rsp_order[$];
  bit            filled[4];
  bit            exp_err = 1'b0;
  int            cmds_left = 0;
  int            force_bad = -1;
  int            cyc = 0, acc_cyc = 0, vld_rise_cyc = 0, err_seen = 0;
  bit            prev_rd_vld, prev_req_stall, prev_rd_stall;
  logic [AW-1:0] prev_addr;
  logic [1:0]    prev_tag;
  logic [DW-1:0] prev_rd_data;
  int            p_cmd, p_mrdy, p_rsp, p_rrdy, p_bad;

  bit   m_exp_vld, m_acc, m_ret, m_legal;
  req_t m_r;
  logic [1:0] m_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] fdat(input logic [AW-1:0] a);
    return {12'hA5A, a, 12'h5C3, ~a};
  endfunction

  function automatic bit is_out(input logic [1:0] t);
    foreach (tag_q[i]) if (tag_q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge mclk) begin
    cyc++;
    if (!mrst_n) begin
      cnt = 0; next_tag = '0; exp_err = 1'b0;
      tag_q.delete(); exp_q.delete(); req_q.delete(); mem_q.delete(); rsp_order.delete();
      for (int i = 0; i < 4; i++) filled[i] = 1'b0;
      prev_rd_vld = 1'b0; prev_req_stall = 1'b0; prev_rd_stall = 1'b0;
    end else begin
      m_exp_vld = (tag_q.size() > 0) && filled[tag_q[0]];
      chk("outstanding", 64'(outstanding), 64'(cnt));
      chk("err_unexp_rsp", 64'(err_unexp_rsp), 64'(exp_err));
      chk("rd_vld", 64'(rd_vld), 64'(m_exp_vld));
      if (m_exp_vld && rd_vld) chk("rd_data", rd_data, exp_q[0]);
      if (prev_rd_stall) chk("rd_data_hold", rd_data, prev_rd_data);
      if (cnt >= 4) chk("cmd_rdy_full", 64'(cmd_rdy), 64'(0));
      else          chk("cmd_rdy", 64'(cmd_rdy), 64'(!mem_req_vld || mem_req_rdy));
      chk("mem_req_vld", 64'(mem_req_vld), 64'(req_q.size() > 0));
      if (prev_req_stall) begin
        chk("req_addr_hold", 64'(mem_req_addr), 64'(prev_addr));
        chk("req_tag_hold", 64'(mem_req_tag), 64'(prev_tag));
      end
      if (mem_req_vld && mem_req_rdy && req_q.size() > 0) begin
        m_r = req_q.pop_front();
        chk("mem_req_addr", 64'(mem_req_addr), 64'(m_r.addr));
        chk("mem_req_tag", 64'(mem_req_tag), 64'(m_r.tag));
        mem_q.push_back({m_r.tag, fdat(m_r.addr)});
      end
      if (err_unexp_rsp) err_seen++;
      m_legal = mem_rsp_vld && is_out(mem_rsp_tag) && !filled[mem_rsp_tag];
      m_ret   = m_exp_vld && rd_rdy;
      m_acc   = cmd_vld && cmd_rdy;
      prev_req_stall = mem_req_vld && !mem_req_rdy;
      prev_addr      = mem_req_addr;
      prev_tag       = mem_req_tag;
      prev_rd_stall  = rd_vld && !rd_rdy;
      prev_rd_data   = rd_data;
      if (rd_vld && !prev_rd_vld) vld_rise_cyc = cyc;
      prev_rd_vld = rd_vld;
      exp_err = mem_rsp_vld && !m_legal;
      if (m_legal) filled[mem_rsp_tag] = 1'b1;
      if (m_ret) begin
        m_t = tag_q.pop_front();
        void'(exp_q.pop_front());
        filled[m_t] = 1'b0;
        cnt--;
      end
      if (m_acc) begin
        tag_q.push_back(next_tag);
        exp_q.push_back(fdat(cmd_addr));
        req_q.push_back({next_tag, cmd_addr});
        next_tag = next_tag + 2'd1;
        cnt++;
        cmds_left--;
        acc_cyc = cyc;
      end
    end
  end

  task automatic set_p(input int c, input int m, input int r, input int d, input int b);
    p_cmd = c; p_mrdy = m; p_rsp = r; p_rrdy = d; p_bad = b;
  endtask

  task automatic cycle();
    int idx;
    logic [1:0] t;
    @(posedge mclk); #1;
    cmd_vld      = (cmds_left > 0) && ($urandom_range(99) < p_cmd);
    cmd_addr     = AW'($urandom);
    mem_req_rdy  = $urandom_range(99) < p_mrdy;
    rd_rdy       = $urandom_range(99) < p_rrdy;
    mem_rsp_vld  = 1'b0;
    mem_rsp_tag  = 2'($urandom);
    mem_rsp_data = {$urandom, $urandom};
    idx = -1;
    if (force_bad >= 0) begin
      mem_rsp_vld = 1'b1;
      mem_rsp_tag = 2'(force_bad);
      force_bad = -1;
    end else if (mem_q.size() > 0 && $urandom_range(99) < p_rsp) begin
      if (rsp_order.size() > 0) begin
        foreach (mem_q[i]) if (mem_q[i].tag == rsp_order[0]) idx = i;
        if (idx >= 0) void'(rsp_order.pop_front());
      end else begin
        idx = int'($urandom_range(mem_q.size() - 1));
      end
      if (idx >= 0) begin
        mem_rsp_vld  = 1'b1;
        mem_rsp_tag  = mem_q[idx].tag;
        mem_rsp_data = mem_q[idx].data;
        mem_q.delete(idx);
      end
    end else if ($urandom_range(99) < p_bad) begin
      t = 2'($urandom);
      if (!is_out(t) || filled[t]) begin
        mem_rsp_vld = 1'b1;
        mem_rsp_tag = t;
      end
    end
  endtask

  task automatic drain();
    int n;
    set_p(100, 100, 100, 100, 0);
    n = 0;
    while (!(cmds_left <= 0 && cnt == 0) && n < 400) begin
      cycle();
      n++;
    end
    cycle();
    if (n >= 400) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: outstanding %0d cmds_left %0d", cnt, cmds_left);
    end
  endtask

  task automatic do_reset();
    @(posedge mclk); #1;
    mrst_n = 1'b0; cmd_vld = 1'b0; mem_req_rdy = 1'b0; mem_rsp_vld = 1'b0; rd_rdy = 1'b0;
    cmds_left = 0; force_bad = -1;
    repeat (2) @(posedge mclk);
    #1 mrst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] b;
    int e0;
    set_p(0, 0, 0, 0, 0);
    repeat (3) @(posedge mclk);
    #1 mrst_n = 1'b1;
    @(negedge mclk);
    chk("rst_cmd_rdy", 64'(cmd_rdy), 64'(1));
    chk("rst_rd_vld", 64'(rd_vld), 64'(0));
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    chk("rst_mem_req_vld", 64'(mem_req_vld), 64'(0));

    // single read with zero-latency memory
    cmds_left = 1; set_p(100, 100, 100, 0, 0);
    repeat (8) cycle();
    @(negedge mclk);
    chk("min_latency", 64'(vld_rise_cyc - acc_cyc), 64'(3));
    chk("single_outstanding", 64'(outstanding), 64'(1));
    drain();

    // fill all four slots, fifth must wait
    cmds_left = 5; set_p(100, 100, 0, 0, 0);
    repeat (10) cycle();
    @(negedge mclk);
    chk("fill_outstanding", 64'(outstanding), 64'(4));
    chk("fill_cmd_rdy", 64'(cmd_rdy), 64'(0));
    chk("fill_fifth_waiting", 64'(cmds_left), 64'(1));
    drain();

    // out-of-order return 3,1,0,2 relative to first tag
    b = next_tag;
    rsp_order.push_back(b + 2'd3); rsp_order.push_back(b + 2'd1);
    rsp_order.push_back(b);        rsp_order.push_back(b + 2'd2);
    cmds_left = 4; set_p(100, 100, 100, 100, 0);
    repeat (30) cycle();
    @(negedge mclk);
    chk("reorder_done", 64'(outstanding), 64'(0));
    drain();

    // backpressure on both sides
    cmds_left = 12; set_p(70, 25, 50, 30, 0);
    repeat (80) cycle();
    drain();

    // unexpected responses: nothing pending, then duplicate of a filled slot
    e0 = err_seen; force_bad = 2;
    repeat (3) cycle();
    chk("err_nothing_pending", 64'(err_seen - e0), 64'(1));
    cmds_left = 1; set_p(100, 100, 100, 0, 0);
    repeat (6) cycle();
    e0 = err_seen;
    force_bad = (tag_q.size() > 0) ? int'(tag_q[0]) : 0;
    repeat (3) cycle();
    chk("err_duplicate", 64'(err_seen - e0), 64'(1));
    chk("dup_rd_vld_kept", 64'(rd_vld), 64'(1));
    drain();

    // reset with three in flight, then a late response
    cmds_left = 3; set_p(100, 100, 0, 0, 0);
    repeat (6) cycle();
    @(negedge mclk);
    chk("pre_reset_outstanding", 64'(outstanding), 64'(3));
    do_reset();
    @(negedge mclk);
    chk("post_reset_outstanding", 64'(outstanding), 64'(0));
    chk("post_reset_rd_vld", 64'(rd_vld), 64'(0));
    e0 = err_seen; force_bad = 1;
    repeat (3) cycle();
    chk("err_late_rsp", 64'(err_seen - e0), 64'(1));
    cmds_left = 10; set_p(80, 70, 60, 70, 0);
    repeat (60) cycle();
    drain();

    // long random run with stray responses
    cmds_left = 300; set_p(60, 60, 50, 60, 10);
    repeat (1500) cycle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/msh_mem_rd_req.md
MSH_MEM_RD_REQ -- requirements
Module: msh_mem_rd_req

Interface
REQ-001 SHALL have parameter ADDR_W, default 20: memory word address width.
REQ-002 SHALL have parameter DATA_W, default 64: read data width.
REQ-003 SHALL fix tag count at 4 (tag width 2); not a parameter.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 mclk  in  1  mesh clock; all state on rising edge.
REQ-006 mrst_n  in  1  async active-low reset.
REQ-007 cmd_vld  in  1  upstream read command valid.
REQ-008 cmd_addr  in  ADDR_W  read address.
REQ-009 cmd_rdy  out  1  command accepted when cmd_vld&&cmd_rdy.
REQ-010 mem_req_vld  out  1  request to memory datapath valid.
REQ-011 mem_req_addr  out  ADDR_W  request address.
REQ-012 mem_req_tag  out  2  request tag.
REQ-013 mem_req_rdy  in  1  memory datapath accepts request.
REQ-014 mem_rsp_vld  in  1  response valid; no backpressure.
REQ-015 mem_rsp_tag  in  2  response tag.
REQ-016 mem_rsp_data  in  DATA_W  response data.
REQ-017 rd_vld  out  1  in-order read data valid.
REQ-018 rd_data  out  DATA_W  read data.
REQ-019 rd_rdy  in  1  downstream accepts when rd_vld&&rd_rdy.
REQ-020 outstanding  out  3  slots allocated, 0..4.
REQ-021 err_unexp_rsp  out  1  one-cycle pulse on unexpected response.

Function
REQ-022 SHALL keep 3-bit issue pointer wp and retire pointer rp; tag = wp[1:0]; outstanding = wp-rp (mod 8), max 4.
REQ-023 SHALL keep per-slot flags pend[4], fill[4] and data buffer buf[4] of DATA_W.
REQ-024 cmd_rdy SHALL equal (outstanding<4) && (!mem_req_vld || mem_req_rdy), combinational from registered state plus mem_req_rdy.
REQ-025 On accept at cycle N: register mem_req_addr=cmd_addr, mem_req_tag=wp[1:0], mem_req_vld=1 visible at N+1; set pend[wp[1:0]]; wp+=1.
REQ-026 mem_req_vld/addr/tag SHALL hold stable until mem_req_rdy; deassert next cycle after handshake unless a new command was accepted the same cycle.
REQ-027 Response with pend[tag]=1 and fill[tag]=0 SHALL write buf[tag]=mem_rsp_data and set fill[tag]; out-of-order return across tags allowed.
REQ-028 Response with pend[tag]=0 or fill[tag]=1 SHALL be dropped (no state change) and err_unexp_rsp=1 on the following cycle only.
REQ-029 rd_vld SHALL equal fill[rp[1:0]]; rd_data SHALL equal buf[rp[1:0]]; stable while rd_vld&&!rd_rdy.
REQ-030 On rd_vld&&rd_rdy: clear pend and fill of rp[1:0]; rp+=1.
REQ-031 Latency: response at cycle M for head slot -> rd_vld at M+1; minimum cmd-to-rd_vld latency 3 cycles with zero-latency memory.
REQ-032 Simultaneous accept and retire: outstanding unchanged; accept into slot being retired in same cycle is blocked since outstanding<4 is evaluated before retire.
REQ-033 Pointer wrap 7->0 SHALL be seamless; tags repeat 0,1,2,3,0...
REQ-034 Response for slot retiring in same cycle cannot be legal (fill=1) and SHALL be flagged per REQ-028.

Reset
REQ-035 mrst_n=0 SHALL clear wp, rp, pend, fill, mem_req_vld, mem_req_addr, mem_req_tag, err_unexp_rsp to 0 asynchronously; buf need not reset.
REQ-036 Reset outputs: cmd_rdy=1 after release, rd_vld=0, outstanding=0, rd_data don't-care.
REQ-037 Reset mid-operation SHALL discard all in-flight requests; responses arriving after release SHALL be flagged per REQ-028.

Verification
REQ-038 Single read: cmd addr 0x00010, mem_req_rdy=1, rsp tag 0 data 0xA5A5 two cycles later -> mem_req tag 0 at N+1, rd_vld with 0xA5A5 one cycle after rsp, outstanding 1->0.
REQ-039 Fill: 5 back-to-back cmds, no responses -> tags 0,1,2,3 issued, cmd_rdy=0 at outstanding=4, fifth accepted only after first retire.
REQ-040 Reorder: 4 reads, responses tags 3,1,0,2 data 0xD,0xB,0xA,0xC -> rd_data order 0xA,0xB,0xC,0xD; rd_vld low until tag 0 arrives.
REQ-041 Backpressure: mem_req_rdy=0 for 3 cycles, rd_rdy=0 for 2 cycles -> mem_req addr/tag and rd_data held stable; no loss or duplication.
REQ-042 Errors: rsp tag 2 with nothing pending; duplicate rsp tag 0 -> err_unexp_rsp one-cycle pulse each, buf/fill unchanged.
REQ-043 Reset mid-flight with outstanding=3, then late rsp tag 1 -> outstanding=0, rd_vld=0, err_unexp_rsp pulse; 10 further reads complete with tag wrap past 7->0.
